shift_add_mult_ctrl: RTL and testbench

Sequencer for a shift-add unsigned multiplier built around the 74181-style 4-bit ALU slice. It owns the accumulator, multiplier shift register and iteration counter, and drives the ALU's operand and mode pins to perform one conditional add per multiplier bit. The ALU slice or slices are instantiated beside it at the multiplier top level. For WIDTH > 4, the top level ripples WIDTH/4 slices via c_in/c_out.

---
 rtl/shift_add_mult_ctrl.sv | 177 +++++++++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: sequencer for a shift-add unsigned multiplier that
// drives an external 74181-style ALU chain (WIDTH/4 slices rippled at the top).
// It owns the accumulator, the multiplier shift register and the bit counter,
// and issues one conditional add per multiplier bit.
// Optional feature macro: SHIFT_ADD_MULT_SKIP_ZERO_EN -- when defined, a zero
// multiplier bit is shifted straight out of the ADD state in a single cycle.
module shift_add_mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [3:0]         alu_s,
    output logic               alu_m,
    output logic               alu_c_in,
    input  logic [WIDTH-1:0]   alu_f,
    input  logic               alu_c_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic                 cy_q, cy_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Result of one right shift of {cy,acc,q} with zero fill.
    logic [WIDTH-1:0]     shift_acc_s;
    logic [WIDTH-1:0]     shift_q_s;
    logic [CW-1:0]        cnt_inc_s;
    logic                 last_bit_s;

    // Shift datapath shared by SHIFT and (optionally) the zero-bit skip in ADD.
    always_comb begin
        shift_acc_s = {cy_q, acc_q[WIDTH-1:1]};
        shift_q_s   = {acc_q[0], q_q[WIDTH-1:1]};
        cnt_inc_s   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        last_bit_s  = (cnt_inc_s == CNT_LAST);
    end

    // Next-state and datapath-update logic of the sequencer.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cy_d      = cy_q;
        q_d       = q_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = multiplicand;
                    q_d     = multiplier;
                    acc_d   = {WIDTH{1'b0}};
                    cy_d    = 1'b0;
                    cnt_d   = {CW{1'b0}};
                    state_d = S_ADD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADD: begin
`ifdef SHIFT_ADD_MULT_SKIP_ZERO_EN
                if (!q_q[0]) begin
                    // Adding zero changes nothing; shift immediately.
                    acc_d = shift_acc_s;
                    q_d   = shift_q_s;
                    cy_d  = 1'b0;
                    cnt_d = cnt_inc_s;
                    if (last_bit_s) begin
                        product_d = {shift_acc_s, shift_q_s};
                        state_d   = S_DONE;
                    end else begin
                        state_d   = S_ADD;
                    end
                end else begin
                    acc_d   = alu_f;
                    cy_d    = alu_c_out;
                    state_d = S_SHIFT;
                end
`else
                acc_d   = alu_f;
                cy_d    = alu_c_out;
                state_d = S_SHIFT;
`endif
            end
            S_SHIFT: begin
                acc_d = shift_acc_s;
                q_d   = shift_q_s;
                cy_d  = 1'b0;
                cnt_d = cnt_inc_s;
                if (last_bit_s) begin
                    product_d = {shift_acc_s, shift_q_s};
                    state_d   = S_DONE;
                end else begin
                    state_d   = S_ADD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_ADD) || (state_d == S_SHIFT);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= {WIDTH{1'b0}};
            cy_q      <= 1'b0;
            q_q       <= {WIDTH{1'b0}};
            mcand_q   <= {WIDTH{1'b0}};
            cnt_q     <= {CW{1'b0}};
            product_q <= {(2*WIDTH){1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cy_q      <= cy_d;
            q_q       <= q_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // ALU pin drive: add in ADD, pass-through (f=a) everywhere else.
    always_comb begin
        alu_a    = acc_q;
        alu_b    = {WIDTH{1'b0}};
        alu_s    = 4'b1111;
        alu_m    = 1'b1;
        alu_c_in = 1'b0;
        if (state_q == S_ADD) begin
            alu_m = 1'b0;
            alu_s = 4'b1001;
            alu_b = q_q[0] ? mcand_q : {WIDTH{1'b0}};
        end else begin
            alu_m = 1'b1;
            alu_s = 4'b1111;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl: behavioural 74181 arithmetic
// model on the ALU pins, random and directed multiplies checked against a*b.
module tb_shift_add_mult_ctrl;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [3:0]     alu_s;
    logic           alu_m;
    logic           alu_c_in;
    logic [W-1:0]   alu_f;
    logic           alu_c_out;

    int n_checks = 0;
    int n_pass   = 0;

    shift_add_mult_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_s        (alu_s),
        .alu_m        (alu_m),
        .alu_c_in     (alu_c_in),
        .alu_f        (alu_f),
        .alu_c_out    (alu_c_out)
    );

    always #5 clk = ~clk;

    // External ALU chain: a+b+c_in in arithmetic mode 1001, f=a in logic mode 1111.
    always_comb begin
        alu_f     = '0;
        alu_c_out = 1'b0;
        if (!alu_m && alu_s == 4'b1001)
            {alu_c_out, alu_f} = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_c_in};
        else if (alu_m && alu_s == 4'b1111)
            alu_f = alu_a;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int exp_latency(input logic [W-1:0] b);
`ifdef SHIFT_ADD_MULT_SKIP_ZERO_EN
        return W + $countones(b);
`else
        return 2 * W;
`endif
    endfunction

    // Wait (at negedges) for done, counting busy cycles; bounded.
    task automatic wait_done(output int busy_cnt, output bit got_done);
        busy_cnt = 0;
        got_done = 0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                got_done = 1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int busy_cnt;
        bit got_done;
        logic [2*W-1:0] exp_p;
        exp_p = ({{W{1'b0}}, a} * {{W{1'b0}}, b});
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        wait_done(busy_cnt, got_done);
        check({tag, "_done_seen"}, 32'(got_done), 32'd1);
        check({tag, "_product"}, 32'(product), 32'(exp_p));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_latency(b)));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        check({tag, "_pass_mode"}, {alu_m, alu_s, alu_c_in}, {1'b1, 4'b1111, 1'b0});
        check({tag, "_pass_b"}, 32'(alu_b), 32'd0);
        check({tag, "_alu_a_acc"}, 32'(alu_a), 32'(exp_p[2*W-1:W]));
        @(negedge clk);
        check({tag, "_done_single"}, 32'(done), 32'd0);
        check({tag, "_product_hold"}, 32'(product), 32'(exp_p));
    endtask

    initial begin
        int busy_cnt;
        bit got_done;
        int done_seen;
        rst = 1'b1;
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_ctl", {alu_m, alu_s, alu_c_in}, {1'b1, 4'b1111, 1'b0});
        rst = 1'b0;

        // Directed cases
        run_mult(4'd13, 4'd11, "m13x11");
        run_mult(4'd15, 4'd15, "m15x15");
        run_mult(4'd0, 4'd9, "m0x9");
        run_mult(4'd9, 4'd0, "m9x0");
        run_mult(4'd9, 4'd8, "m9x8");

        // start held high, operands changing mid-run
        @(negedge clk);
        multiplicand = 4'd3;
        multiplier   = 4'd5;
        start        = 1'b1;
        @(negedge clk);
        multiplicand = 4'd14;
        multiplier   = 4'd13;
        wait_done(busy_cnt, got_done);
        check("held1_done_seen", 32'(got_done), 32'd1);
        check("held1_product", 32'(product), 32'd15);
        multiplicand = 4'd7;
        multiplier   = 4'd9;
        @(negedge clk);
        check("held_idle_busy", 32'(busy), 32'd0);
        check("held_idle_done", 32'(done), 32'd0);
        @(negedge clk);
        multiplicand = 4'd2;
        multiplier   = 4'd2;
        wait_done(busy_cnt, got_done);
        start = 1'b0;
        check("held2_done_seen", 32'(got_done), 32'd1);
        check("held2_product", 32'(product), 32'd63);
        @(negedge clk);

        // rst during the third ADD cycle
        @(negedge clk);
        multiplicand = 4'd13;
        multiplier   = 4'd11;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_product", 32'(product), 32'd0);
        check("midrst_alu_ctl", {alu_m, alu_s, alu_c_in}, {1'b1, 4'b1111, 1'b0});
        check("midrst_alu_a", 32'(alu_a), 32'd0);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        check("midrst_no_done", 32'(done_seen), 32'd0);
        run_mult(4'd6, 4'd7, "m6x7");

        // Randomized multiplies
        for (int k = 0; k < 24; k++)
            run_mult(W'($urandom), W'($urandom), "rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
